tmr_fault_monitor: RTL
======================

// Module: tmr_fault_monitor
// PURPOSE
// - Consumer end of a TMR replica bus: samples three replica values, votes, and tracks per-lane health.
// - Flags per-sample mismatches and keeps a 3-state health FSM plus a saturating error counter per lane.
// - Reports health transitions to a supervisor over a valid/ready event port.
// - Sits between the TMR datapath (the replicated counters) and the system supervisor/logger.
// PARAMETERS
// - WIDTH        128  replica data width
// - FAIL_THRESH  4    consecutive mismatching samples (incl. the first) that move a lane to FAILED; >=2
// - CNT_W        16   width of each per-lane error counter
// PORTS
// - clk          in   1        clock; all logic on posedge
// - rst          in   1        asynchronous, active-high reset
// - sample_valid in   1        q_1..q_3 are valid this cycle
// - q_1,q_2,q_3  in   WIDTH    replica values
// - clr_stats    in   1        synchronous clear of states, counters, pending events, overflow
// - voted_q      out  WIDTH    registered voted value
// - fault        out  3        registered per-lane mismatch vs voted value, bit i-1 = lane i
// - no_majority  out  1        registered: all three replicas pairwise different
// - lane_state   out  6        {lane3,lane2,lane1} health, 2 b each
// - err_cnt_1/2/3 out CNT_W    saturating mismatch count per lane
// - evt_valid    out  1        event available
// - evt_ready    in   1        supervisor accepts event
// - evt_lane     out  2        1..3 = lane, 0 = no-majority event
// - evt_kind     out  2        01 SUSPECT, 10 FAILED, 11 NO_MAJORITY
// - evt_overflow out  1        sticky: an event was raised while the same event was still pending
// BEHAVIOUR
// - Reset: voted_q=0, fault=0, no_majority=0, all lanes OK, counters 0, no pending, evt_valid=0, evt_lane=0, evt_kind=0, overflow=0.
// - Vote: q_1 if q_1==q_2 or q_1==q_3; else q_2 if q_2==q_3; else bitwise majority (q1&q2)|(q1&q3)|(q2&q3) and no_majority=1.
// - Lane i mismatch = (q_i != vote). Outputs voted_q/fault/no_majority update 1 cycle after sample_valid; held otherwise.
// - Error counter: +1 per mismatching valid sample; saturates at 2^CNT_W-1, never wraps.
// - Lane FSM (encoding OK=00, SUSPECT=01, FAILED=10; 11 unused, recovers to OK):
//   OK: mismatch -> SUSPECT, run=1, raise SUSPECT event.
//   SUSPECT: mismatch -> run+1; when run reaches FAIL_THRESH -> FAILED, raise FAILED event. match -> OK, run=0.
//   FAILED: sticky; leaves only via clr_stats or rst. Counter keeps counting.
// - States/counters/run update on the same edge as fault (latency 1); cycles without sample_valid leave them unchanged.
// - Events: 7 pending bits (SUSPECT x3, FAILED x3, NO_MAJORITY); each set when raised, cleared when issued.
//   Raise while same bit already pending -> bit stays set, evt_overflow=1.
//   Output register: when empty (or being emptied by handshake) load highest-priority pending bit:
//   FAILED lane1..3, then SUSPECT lane1..3, then NO_MAJORITY. Event raised in cycle N is visible no earlier than N+2.
//   evt_valid/evt_lane/evt_kind stable while evt_valid && !evt_ready; transfer on evt_valid && evt_ready.
//   Back-to-back: with evt_ready held high, one event per cycle.
// - clr_stats: wins over sample_valid in the same cycle (sample discarded); clears lane states, run, counters,
//   pending bits, overflow, and drops evt_valid; voted_q/fault/no_majority also cleared to 0.
// - rst mid-operation: asynchronous return to reset values, including an un-acknowledged event.
// STRUCTURE
// - tmr_pkg: lane_state_t enum (OK, SUSPECT, FAILED), evt_kind_t enum, EVT_LANE_NOMAJ=2'd0 constant.
// - Sub-module tmr_lane_fsm (FSM + run counter + saturating err counter + raise outputs), instantiated 3x.
// - Voter, pending bits, priority selector and event output register live in tmr_fault_monitor.
// TESTING
// - Reset, then sample q=5,5,5 -> next cycle voted_q=5, fault=000, all lanes OK, evt_valid=0.
// - q_2=9, others 5, one sample -> voted_q=5, fault=010, lane2 SUSPECT, err_cnt_2=1; event {lane 2, SUSPECT}; next sample all 5 -> lane2 OK.
// - q_3=7 for 4 consecutive samples (FAIL_THRESH=4) -> lane3 FAILED after 4th; events SUSPECT then FAILED lane3 in order; stays FAILED on matching samples until clr_stats.
// - q=1,2,4 -> voted_q=0, no_majority=1, fault=111, event lane 0 kind 11; all three lanes SUSPECT events issued FAILED-first priority order.
// - evt_ready=0 while lane1 SUSPECT pending and another lane1 SUSPECT raised -> evt_overflow=1, outputs stable; CNT_W=2, 5 mismatches -> err_cnt=3.
// - clr_stats with sample_valid same cycle -> all cleared, sample ignored; rst asserted with evt_valid=1 -> evt_valid=0 immediately.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types for the TMR fault monitor: lane health states, event kinds and event slot layout.
package tmr_pkg;

  typedef enum logic [1:0] {
    LANE_OK      = 2'b00,
    LANE_SUSPECT = 2'b01,
    LANE_FAILED  = 2'b10
  } lane_state_t;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_SUSPECT = 2'b01,
    EVT_FAILED  = 2'b10,
    EVT_NOMAJ   = 2'b11
  } evt_kind_t;

  localparam logic [1:0] EVT_LANE_NOMAJ = 2'd0;
  localparam int unsigned NUM_LANES = 3;
  // Pending slots: [2:0] FAILED lane1..3, [5:3] SUSPECT lane1..3, [6] NO_MAJORITY (lowest index wins)
  localparam int unsigned NUM_EVT = 7;

endpackage

// File: rtl/tmr_lane_fsm.sv
// Per-lane health tracker: OK/SUSPECT/FAILED state, mismatch run length and saturating error count.
module tmr_lane_fsm
  import tmr_pkg::*;
#(
  parameter int unsigned FAIL_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             smp,
  input  logic             clr,
  input  logic             mismatch,
  output lane_state_t      state,
  output logic [CNT_W-1:0] err_cnt,
  output logic             raise_suspect_c,
  output logic             raise_failed_c
);

  localparam int unsigned RUN_W = $clog2(FAIL_THRESH + 1);

  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc_c;
  logic             fail_hit_c;

  assign run_inc_c       = run + RUN_W'(1);
  assign fail_hit_c      = (run_inc_c >= RUN_W'(FAIL_THRESH));
  assign raise_suspect_c = smp && mismatch && (state == LANE_OK);
  assign raise_failed_c  = smp && mismatch && (state == LANE_SUSPECT) && fail_hit_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LANE_OK;
      run     <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      state   <= LANE_OK;
      run     <= '0;
      err_cnt <= '0;
    end else if (smp) begin
      if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      case (state)
        LANE_OK: begin
          if (mismatch) begin
            state <= LANE_SUSPECT;
            run   <= RUN_W'(1);
          end
        end
        LANE_SUSPECT: begin
          if (mismatch) begin
            run <= run_inc_c;
            if (fail_hit_c) state <= LANE_FAILED;
          end else begin
            state <= LANE_OK;
            run   <= '0;
          end
        end
        // FAILED is sticky until clr or rst; only the counter keeps moving
        LANE_FAILED: run <= '0;
        default: begin
          state <= LANE_OK;
          run   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// TMR consumer: votes three replicas, tracks per-lane health and reports health events over valid/ready.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned FAIL_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic             clr_stats,
  output logic [WIDTH-1:0] voted_q,
  output logic [2:0]       fault,
  output logic             no_majority,
  output logic [5:0]       lane_state,
  output logic [CNT_W-1:0] err_cnt_1,
  output logic [CNT_W-1:0] err_cnt_2,
  output logic [CNT_W-1:0] err_cnt_3,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_lane,
  output logic [1:0]       evt_kind,
  output logic             evt_overflow
);

  logic                 smp_c;
  logic [WIDTH-1:0]     maj_c;
  logic [WIDTH-1:0]     vote_c;
  logic                 nomaj_c;
  logic [2:0]           mism_c;
  lane_state_t          lane_st [NUM_LANES];
  logic [CNT_W-1:0]     cnt [NUM_LANES];
  logic [2:0]           rs_c;
  logic [2:0]           rf_c;
  logic [NUM_EVT-1:0]   raise_c;
  logic [NUM_EVT-1:0]   pend;
  logic [NUM_EVT-1:0]   sel_oh_c;
  logic [NUM_EVT-1:0]   issue_c;
  logic [1:0]           sel_lane_c;
  evt_kind_t            sel_kind_c;
  logic                 load_c;

  // A clear in the same cycle discards the sample entirely
  assign smp_c = sample_valid && !clr_stats;
  assign maj_c = (q_1 & q_2) | (q_1 & q_3) | (q_2 & q_3);

  always_comb begin
    vote_c  = maj_c;
    nomaj_c = 1'b0;
    if ((q_1 == q_2) || (q_1 == q_3)) vote_c = q_1;
    else if (q_2 == q_3)              vote_c = q_2;
    else                              nomaj_c = 1'b1;
  end

  assign mism_c = {q_3 != vote_c, q_2 != vote_c, q_1 != vote_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voted_q     <= '0;
      fault       <= '0;
      no_majority <= 1'b0;
    end else if (clr_stats) begin
      voted_q     <= '0;
      fault       <= '0;
      no_majority <= 1'b0;
    end else if (sample_valid) begin
      voted_q     <= vote_c;
      fault       <= mism_c;
      no_majority <= nomaj_c;
    end
  end

  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    tmr_lane_fsm #(
      .FAIL_THRESH(FAIL_THRESH),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk            (clk),
      .rst            (rst),
      .smp            (smp_c),
      .clr            (clr_stats),
      .mismatch       (mism_c[i]),
      .state          (lane_st[i]),
      .err_cnt        (cnt[i]),
      .raise_suspect_c(rs_c[i]),
      .raise_failed_c (rf_c[i])
    );
  end

  assign lane_state = {lane_st[2], lane_st[1], lane_st[0]};
  assign err_cnt_1  = cnt[0];
  assign err_cnt_2  = cnt[1];
  assign err_cnt_3  = cnt[2];
  assign raise_c    = {nomaj_c && smp_c, rs_c, rf_c};

  // Priority pick: lowest pending slot index wins
  always_comb begin
    sel_oh_c   = '0;
    sel_lane_c = '0;
    sel_kind_c = EVT_NONE;
    for (int i = int'(NUM_EVT) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_oh_c    = '0;
        sel_oh_c[i] = 1'b1;
        sel_lane_c  = (i == int'(NUM_EVT) - 1) ? EVT_LANE_NOMAJ : 2'((i % 3) + 1);
        sel_kind_c  = (i < 3) ? EVT_FAILED : ((i < 6) ? EVT_SUSPECT : EVT_NOMAJ);
      end
    end
  end

  assign load_c  = (!evt_valid || evt_ready) && (|pend);
  assign issue_c = load_c ? sel_oh_c : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend         <= '0;
      evt_overflow <= 1'b0;
    end else if (clr_stats) begin
      pend         <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend <= (pend & ~issue_c) | raise_c;
      if (|(raise_c & pend & ~issue_c)) evt_overflow <= 1'b1;
    end
  end

  // Event output register: held while stalled, refilled on the handshake edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_lane  <= '0;
      evt_kind  <= '0;
    end else if (clr_stats) begin
      evt_valid <= 1'b0;
      evt_lane  <= '0;
      evt_kind  <= '0;
    end else if (load_c) begin
      evt_valid <= 1'b1;
      evt_lane  <= sel_lane_c;
      evt_kind  <= sel_kind_c;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
